mcuspi_tx: RTL and testbench
============================

Name: mcuspi_tx

Overview:
- SPI slave transmitter toward the MCU (mode 0, MSB first); companion of the MCU-to-FPGA SPI receive path on the same mcu_csn/mcu_sck pins.
- Internal logic pushes bytes into a small FIFO; the block shifts them out on mcu_miso while the MCU clocks mcu_sck with mcu_csn low.
- All SPI inputs are oversampled in the clk_sys domain. No SPI clock drives flops.

Parameters:
- FIFO_DEPTH, 4: byte FIFO depth; must be a power of 2, at least 2.
- AW, 2: log2(FIFO_DEPTH).
- IDLE_BYTE, 8'hFF: byte transmitted when the FIFO is empty at a byte boundary.

Ports:
- clk_sys  input  1  system clock.
- rst  input  1  reset, asynchronous, active-high.
- mcu_csn  input  1  MCU chip select, active low, asynchronous.
- mcu_sck  input  1  MCU SPI clock, idles low, asynchronous.
- mcu_miso  output  1  serial data to the MCU.
- mcu_miso_oe  output  1  output enable for the miso pad driver; 1 = drive.
- tx_data  input  8  byte to queue.
- tx_vld  input  1  push request.
- tx_rdy  output  1  FIFO not full.
- tx_level  output  AW+1  FIFO occupancy, 0..FIFO_DEPTH.
- tx_busy  output  1  high while the state is not IDLE.
- tx_done  output  1  1-cycle pulse per fully shifted byte.
- tx_underrun  output  1  1-cycle pulse when IDLE_BYTE is loaded because the FIFO is empty.

Behaviour:
- Reset values:
  - All registers cleared.
  - mcu_miso=0, mcu_miso_oe=0, tx_level=0, tx_busy=0, tx_done=0, tx_underrun=0.
  - tx_rdy=1.
- Synchronisation:
  - mcu_csn and mcu_sck each pass through a 2-FF synchroniser, then an edge-detect register.
  - Edges are seen 3 clk_sys cycles after the pin toggles.
  - Requirement: sck high and low phases are each at least 4 clk_sys cycles.
- FIFO:
  - A push occurs when tx_vld and tx_rdy are both high.
  - A push while full is ignored; the level does not change.
  - A push and a pop in the same cycle leave the level unchanged.
  - A pop reads the head byte. Pointers wrap modulo FIFO_DEPTH.
  - tx_rdy = (tx_level != FIFO_DEPTH).
- Shift register sreg[7:0]. mcu_miso = sreg[7], registered.
- State machine:
  - IDLE:
    - mcu_miso_oe=0, bit counter cleared.
    - On a synced csn falling edge, go to LOAD.
  - LOAD (one cycle):
    - If the FIFO is not empty, pop into sreg.
    - Otherwise load IDLE_BYTE into sreg and pulse tx_underrun.
    - Set mcu_miso_oe=1, go to SHIFT.
    - The MSB is on the pin before the first sck rising edge. The MCU must wait at least 6 clk_sys cycles from csn low to the first sck rise.
  - SHIFT:
    - Synced sck rising edge: increment the 3-bit bit counter. On the 8th rise (counter wraps 7->0), set the byte_end flag and pulse tx_done.
    - Synced sck falling edge with byte_end=1: clear byte_end, then pop the next byte or load IDLE_BYTE (pulse tx_underrun if empty). Bytes are back-to-back, with no gap cycle.
    - Synced sck falling edge with byte_end=0: shift sreg left by 1.
    - Synced csn rising edge: go to IDLE. Set oe=0 in the same cycle, clear the counter and byte_end, and discard any partial byte (no tx_done, no refund to the FIFO).
- Simultaneous events:
  - A csn rise has priority over an sck edge in the same cycle.
  - A push during a pop cycle is allowed, including when the FIFO is full and a pop occurs: the push is accepted only if tx_rdy was high that cycle.
- Asynchronous reset mid-transfer returns to IDLE immediately, with oe=0 and the FIFO emptied.
- A csn falling edge seen while not in IDLE cannot occur. If csn glitches, the csn-rise handling governs.

Test Plan:
- Reset, then push 8'hA5. Drive csn low, then 8 sck cycles of 10 clk_sys per phase. The MCU samples on sck rise and reads 1,0,1,0,0,1,0,1. Exactly one tx_done; tx_level goes 1->0; tx_underrun stays 0; oe drops within 4 cycles of csn high.
- Push 8'h3C, 8'hC3, 8'h01. Run a 24-bit transfer. The MCU reads 3C C3 01 with no bit slip. Three tx_done pulses; tx_level ends at 0.
- Empty FIFO, then a 16-bit transfer. The MCU reads FF FF; two tx_underrun pulses; zero pops.
- Push 5 bytes with FIFO_DEPTH=4. tx_rdy goes low after the 4th push; the 5th byte is dropped; tx_level=4. A transfer of 4 bytes returns the first four bytes in order.
- Push 8'hF0, 8'h0F. Raise csn after 4 bits. No tx_done; tx_level=1. The next transfer returns 8'h0F.
- Assert rst during bit 3 of a transfer. mcu_miso_oe=0 and tx_level=0 in the same cycle. After release, tx_rdy=1 and the next transfer with an empty FIFO returns 8'hFF.

Source files
------------

// File: rtl/mcuspi_tx.sv
// SPI mode-0 slave transmitter toward the MCU: a byte FIFO feeds a shift register whose MSB drives
// mcu_miso. All SPI pins are oversampled in clk_sys, and no SPI clock drives any flop.
module mcuspi_tx #(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned AW         = 2,
    parameter logic [7:0]  IDLE_BYTE  = 8'hFF
) (
    input  logic          clk_sys,
    input  logic          rst,
    input  logic          mcu_csn,
    input  logic          mcu_sck,
    output logic          mcu_miso,
    output logic          mcu_miso_oe,
    input  logic [7:0]    tx_data,
    input  logic          tx_vld,
    output logic          tx_rdy,
    output logic [AW:0]   tx_level,
    output logic          tx_busy,
    output logic          tx_done,
    output logic          tx_underrun
);

    typedef enum logic [1:0] {StIdle, StLoad, StShift} state_e;

    localparam logic [AW:0] FullLvl = FIFO_DEPTH[AW:0];

    logic          csn_meta_q, csn_sync_q, csn_prev_q;
    logic          sck_meta_q, sck_sync_q, sck_prev_q;
    logic          csn_fall, csn_rise, sck_fall, sck_rise;

    logic [7:0]    mem_q [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0]   level_q;
    logic          fifo_empty, push, pop, load_now;
    logic [7:0]    load_byte;

    state_e        state_q;
    logic [7:0]    sreg_q;
    logic [2:0]    cnt_q;
    logic          byte_end_q, oe_q, done_q, underrun_q;

    // Two-flop synchronisers followed by one edge-detect stage per pin.
    always_ff @(posedge clk_sys or posedge rst) begin
        if (rst) begin
            csn_meta_q <= 1'b0;
            csn_sync_q <= 1'b0;
            csn_prev_q <= 1'b0;
            sck_meta_q <= 1'b0;
            sck_sync_q <= 1'b0;
            sck_prev_q <= 1'b0;
        end else begin
            csn_meta_q <= mcu_csn;
            csn_sync_q <= csn_meta_q;
            csn_prev_q <= csn_sync_q;
            sck_meta_q <= mcu_sck;
            sck_sync_q <= sck_meta_q;
            sck_prev_q <= sck_sync_q;
        end
    end

    always_comb begin
        csn_fall = csn_prev_q & ~csn_sync_q;
        csn_rise = ~csn_prev_q & csn_sync_q;
        sck_fall = sck_prev_q & ~sck_sync_q;
        sck_rise = ~sck_prev_q & sck_sync_q;
    end

    // A byte is loaded in LOAD and on the sck fall that closes a byte, unless csn rose that cycle.
    always_comb begin
        fifo_empty = (level_q == '0);
        load_now   = (state_q == StLoad) ||
                     ((state_q == StShift) && !csn_rise && sck_fall && byte_end_q);
        pop        = load_now && !fifo_empty;
        push       = tx_vld && tx_rdy;
        load_byte  = fifo_empty ? IDLE_BYTE : mem_q[rd_ptr_q];
    end

    always_ff @(posedge clk_sys or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (push) begin
                mem_q[wr_ptr_q] <= tx_data;
                wr_ptr_q        <= wr_ptr_q + AW'(1);
            end
            if (pop) rd_ptr_q <= rd_ptr_q + AW'(1);
            if (push && !pop)      level_q <= level_q + (AW+1)'(1);
            else if (pop && !push) level_q <= level_q - (AW+1)'(1);
        end
    end

    always_ff @(posedge clk_sys or posedge rst) begin
        if (rst) begin
            state_q    <= StIdle;
            sreg_q     <= '0;
            cnt_q      <= '0;
            byte_end_q <= 1'b0;
            oe_q       <= 1'b0;
            done_q     <= 1'b0;
            underrun_q <= 1'b0;
        end else begin
            done_q     <= 1'b0;
            underrun_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    oe_q       <= 1'b0;
                    cnt_q      <= '0;
                    byte_end_q <= 1'b0;
                    if (csn_fall) state_q <= StLoad;
                end
                StLoad: begin
                    sreg_q     <= load_byte;
                    underrun_q <= fifo_empty;
                    oe_q       <= 1'b1;
                    state_q    <= StShift;
                end
                StShift: begin
                    if (csn_rise) begin
                        state_q    <= StIdle;
                        oe_q       <= 1'b0;
                        cnt_q      <= '0;
                        byte_end_q <= 1'b0;
                    end else if (sck_rise) begin
                        cnt_q <= cnt_q + 3'd1;
                        if (cnt_q == 3'd7) begin
                            byte_end_q <= 1'b1;
                            done_q     <= 1'b1;
                        end
                    end else if (sck_fall) begin
                        if (byte_end_q) begin
                            byte_end_q <= 1'b0;
                            sreg_q     <= load_byte;
                            underrun_q <= fifo_empty;
                        end else begin
                            sreg_q <= {sreg_q[6:0], 1'b0};
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    always_comb begin
        mcu_miso    = sreg_q[7];
        mcu_miso_oe = oe_q;
        tx_level    = level_q;
        tx_rdy      = (level_q != FullLvl);
        tx_busy     = (state_q != StIdle);
        tx_done     = done_q;
        tx_underrun = underrun_q;
    end

endmodule

// File: tb/tb_mcuspi_tx.sv
// Bench for mcuspi_tx: an MCU-side SPI master plus a queue model of the FIFO, with idle-byte fill.
module tb_mcuspi_tx;

    logic       clk_sys = 1'b0;
    logic       rst, mcu_csn, mcu_sck, mcu_miso, mcu_miso_oe;
    logic [7:0] tx_data;
    logic       tx_vld, tx_rdy, tx_busy, tx_done, tx_underrun;
    logic [2:0] tx_level;

    int n_checks = 0;
    int n_fail   = 0;
    int done_cnt = 0;
    int unr_cnt  = 0;

    logic [7:0] model_q[$];
    logic [7:0] exp_q[$];
    int         exp_unr;
    logic       rx_bits[$];
    int         oe_bad;
    logic       oe_after;

    mcuspi_tx #(.FIFO_DEPTH(4), .AW(2), .IDLE_BYTE(8'hFF)) dut (
        .clk_sys     (clk_sys),
        .rst         (rst),
        .mcu_csn     (mcu_csn),
        .mcu_sck     (mcu_sck),
        .mcu_miso    (mcu_miso),
        .mcu_miso_oe (mcu_miso_oe),
        .tx_data     (tx_data),
        .tx_vld      (tx_vld),
        .tx_rdy      (tx_rdy),
        .tx_level    (tx_level),
        .tx_busy     (tx_busy),
        .tx_done     (tx_done),
        .tx_underrun (tx_underrun)
    );

    always #5 clk_sys = ~clk_sys;

    always @(posedge clk_sys) begin
        if (!rst && tx_done) done_cnt++;
        if (!rst && tx_underrun) unr_cnt++;
    end

    // Model: queue of accepted bytes; each load takes the head or the idle byte.
    task automatic push_byte(input logic [7:0] b);
        logic exp_rdy;
        exp_rdy = (model_q.size() < 4);
        n_checks++;
        if (tx_rdy !== exp_rdy) begin
            n_fail++;
            $display("FAIL push_rdy: got %b want %b", tx_rdy, exp_rdy);
        end
        tx_data = b;
        tx_vld  = 1'b1;
        @(negedge clk_sys);
        tx_vld = 1'b0;
        if (exp_rdy) model_q.push_back(b);
    endtask

    task automatic model_xfer(input int nbits);
        exp_q.delete();
        exp_unr = 0;
        for (int k = 0; k < (nbits + 7) / 8; k++) begin
            if (model_q.size() > 0) exp_q.push_back(model_q.pop_front());
            else begin
                exp_q.push_back(8'hFF);
                exp_unr++;
            end
        end
    endtask

    function automatic logic [7:0] rx_byte(input int k);
        logic [7:0] v;
        for (int i = 0; i < 8; i++) v[7-i] = rx_bits[8*k+i];
        return v;
    endfunction

    // MCU master: samples miso just before each sck rise; last sck fall coincides with csn rise.
    task automatic run_xfer(input int nbits, input int ph);
        rx_bits.delete();
        oe_bad  = 0;
        mcu_csn = 1'b0;
        repeat (8) @(negedge clk_sys);
        for (int i = 0; i < nbits; i++) begin
            if (mcu_miso_oe !== 1'b1) oe_bad++;
            rx_bits.push_back(mcu_miso);
            mcu_sck = 1'b1;
            repeat (ph) @(negedge clk_sys);
            mcu_sck = 1'b0;
            if (i == nbits - 1) begin
                mcu_csn = 1'b1;
                repeat (4) @(negedge clk_sys);
                oe_after = mcu_miso_oe;
                repeat (4) @(negedge clk_sys);
            end else begin
                repeat (ph) @(negedge clk_sys);
            end
        end
    endtask

    task automatic test_reset();
        n_checks++;
        if ({mcu_miso, mcu_miso_oe, tx_busy, tx_done, tx_underrun} !== 5'b0) begin
            n_fail++;
            $display("FAIL reset_outs: got %b want 00000",
                     {mcu_miso, mcu_miso_oe, tx_busy, tx_done, tx_underrun});
        end
        n_checks++;
        if (tx_level !== 3'd0 || tx_rdy !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_fifo: got level %0d rdy %b want 0 1", tx_level, tx_rdy);
        end
    endtask

    task automatic test_single();
        int d0, u0;
        push_byte(8'hA5);
        n_checks++;
        if (tx_level !== 3'd1) begin
            n_fail++;
            $display("FAIL single_lvl_pre: got %0d want 1", tx_level);
        end
        model_xfer(8);
        d0 = done_cnt; u0 = unr_cnt;
        run_xfer(8, 10);
        n_checks++;
        if (rx_byte(0) !== exp_q[0]) begin
            n_fail++;
            $display("FAIL single_data: got %h want %h", rx_byte(0), exp_q[0]);
        end
        n_checks++;
        if (done_cnt - d0 != 1 || unr_cnt - u0 != 0) begin
            n_fail++;
            $display("FAIL single_pulses: got done %0d unr %0d want 1 0",
                     done_cnt - d0, unr_cnt - u0);
        end
        n_checks++;
        if (tx_level !== 3'd0 || oe_after !== 1'b0 || oe_bad != 0) begin
            n_fail++;
            $display("FAIL single_end: got level %0d oe_after %b oe_bad %0d want 0 0 0",
                     tx_level, oe_after, oe_bad);
        end
    endtask

    task automatic test_multi(input int nbytes, input int ph, input string name);
        int d0, u0;
        model_xfer(8 * nbytes);
        d0 = done_cnt; u0 = unr_cnt;
        run_xfer(8 * nbytes, ph);
        for (int k = 0; k < nbytes; k++) begin
            n_checks++;
            if (rx_byte(k) !== exp_q[k]) begin
                n_fail++;
                $display("FAIL %s_byte%0d: got %h want %h", name, k, rx_byte(k), exp_q[k]);
            end
        end
        n_checks++;
        if (done_cnt - d0 != nbytes || unr_cnt - u0 != exp_unr) begin
            n_fail++;
            $display("FAIL %s_pulses: got done %0d unr %0d want %0d %0d", name,
                     done_cnt - d0, unr_cnt - u0, nbytes, exp_unr);
        end
        n_checks++;
        if (tx_level !== 3'(model_q.size()) || oe_after !== 1'b0 || oe_bad != 0) begin
            n_fail++;
            $display("FAIL %s_end: got level %0d oe_after %b oe_bad %0d want %0d 0 0", name,
                     tx_level, oe_after, oe_bad, model_q.size());
        end
    endtask

    task automatic test_overflow();
        for (int i = 0; i < 5; i++) push_byte(8'h10 + 8'(i));
        n_checks++;
        if (tx_level !== 3'd4 || tx_rdy !== 1'b0) begin
            n_fail++;
            $display("FAIL ovf_full: got level %0d rdy %b want 4 0", tx_level, tx_rdy);
        end
        test_multi(4, 10, "ovf");
    endtask

    task automatic test_abort();
        int d0;
        push_byte(8'hF0);
        push_byte(8'h0F);
        model_xfer(4);
        d0 = done_cnt;
        run_xfer(4, 10);
        n_checks++;
        if (rx_byte_partial() !== exp_q[0][7:4]) begin
            n_fail++;
            $display("FAIL abort_bits: got %h want %h", rx_byte_partial(), exp_q[0][7:4]);
        end
        n_checks++;
        if (done_cnt != d0 || tx_level !== 3'd1) begin
            n_fail++;
            $display("FAIL abort_state: got done %0d level %0d want 0 1", done_cnt - d0, tx_level);
        end
        test_multi(1, 10, "after_abort");
    endtask

    function automatic logic [3:0] rx_byte_partial();
        return {rx_bits[0], rx_bits[1], rx_bits[2], rx_bits[3]};
    endfunction

    task automatic test_reset_mid();
        push_byte(8'h12);
        push_byte(8'h34);
        mcu_csn = 1'b0;
        repeat (8) @(negedge clk_sys);
        for (int i = 0; i < 3; i++) begin
            mcu_sck = 1'b1; repeat (10) @(negedge clk_sys);
            mcu_sck = 1'b0; repeat (10) @(negedge clk_sys);
        end
        mcu_sck = 1'b1;
        repeat (5) @(negedge clk_sys);
        rst = 1'b1;
        #1;
        n_checks++;
        if (mcu_miso_oe !== 1'b0 || tx_level !== 3'd0 || tx_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_mid: got oe %b level %0d busy %b want 0 0 0",
                     mcu_miso_oe, tx_level, tx_busy);
        end
        model_q.delete();
        mcu_sck = 1'b0;
        mcu_csn = 1'b1;
        repeat (4) @(negedge clk_sys);
        rst = 1'b0;
        repeat (6) @(negedge clk_sys);
        n_checks++;
        if (tx_rdy !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_rdy: got %b want 1", tx_rdy);
        end
        test_multi(1, 10, "post_rst");
    endtask

    task automatic test_random();
        int np, nb, ph;
        for (int r = 0; r < 6; r++) begin
            np = $urandom_range(0, 5);
            for (int i = 0; i < np; i++) push_byte(8'($urandom));
            n_checks++;
            if (tx_level !== 3'(model_q.size())) begin
                n_fail++;
                $display("FAIL rnd%0d_lvl: got %0d want %0d", r, tx_level, model_q.size());
            end
            nb = $urandom_range(1, 4);
            ph = $urandom_range(5, 9);
            test_multi(nb, ph, "rnd");
        end
    endtask

    initial begin
        rst = 1'b1; mcu_csn = 1'b1; mcu_sck = 1'b0; tx_vld = 1'b0; tx_data = 8'h00;
        repeat (3) @(negedge clk_sys);
        rst = 1'b0;
        repeat (6) @(negedge clk_sys);
        test_reset();
        test_single();
        push_byte(8'h3C);
        push_byte(8'hC3);
        push_byte(8'h01);
        test_multi(3, 10, "three");
        test_multi(2, 10, "empty");
        test_overflow();
        test_abort();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
